// File: rtl/ssr_gearbox.sv
//==============================================================================
// Module     : ssr_gearbox
// Description: Regroups NIN samples per qualified clock into NOUT-sample words.
//              Optional status outputs (err_o, fill_o) under SSR_GEARBOX_STATUS_EN.
// Revision   : 1.0 - initial release
//==============================================================================
`default_nettype none

module ssr_gearbox #(
    parameter int NBITS = 12,
    parameter int NIN   = 4,
    parameter int NOUT  = 6,
    localparam int BUF  = NIN + NOUT - 1,
    localparam int CNTW = $clog2(BUF + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ce_i,
    input  logic                  sync_i,
    input  logic [NIN*NBITS-1:0]  dat_i,
    output logic [NOUT*NBITS-1:0] dat_o,
    output logic                  ce_o,
    output logic                  err_o,
    output logic [CNTW-1:0]       fill_o
);

    logic [BUF*NBITS-1:0]  buf_q, buf_d;
    logic [CNTW-1:0]       cnt_q, cnt_d;
    logic [NOUT*NBITS-1:0] dat_q, dat_d;
    logic                  ce_q, ce_d;

    int                    w_base;
    int                    w_total;
    logic                  w_ovf;
    logic                  w_acc;
    logic [BUF*NBITS-1:0]  w_buf;

    always_comb begin
        w_base  = sync_i ? 0 : int'(cnt_q);
        w_ovf   = ce_i && ((w_base + NIN) > BUF);
        w_acc   = ce_i && !w_ovf;
        w_total = w_base + (w_acc ? NIN : 0);

        // Positions at or above w_base hold stale data, so overwriting is safe.
        w_buf = buf_q;
        if (w_acc) begin
            for (int k = 0; k < NIN; k++) begin
                w_buf[(w_base + k)*NBITS +: NBITS] = dat_i[k*NBITS +: NBITS];
            end
        end

        buf_d = w_buf;
        cnt_d = CNTW'(w_total);
        dat_d = dat_q;
        ce_d  = 1'b0;
        if (w_total >= NOUT) begin
            dat_d = w_buf[NOUT*NBITS-1:0];
            buf_d = w_buf >> (NOUT*NBITS);
            cnt_d = CNTW'(w_total - NOUT);
            ce_d  = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_q <= '0;
            cnt_q <= '0;
            dat_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
            dat_q <= dat_d;
            ce_q  <= ce_d;
        end
    end

    assign dat_o = dat_q;
    assign ce_o  = ce_q;

`ifdef SSR_GEARBOX_STATUS_EN
    logic err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_q <= 1'b0;
        end else if (w_ovf) begin
            err_q <= 1'b1;
        end
    end

    assign err_o  = err_q;
    assign fill_o = cnt_q;
`else
    assign err_o  = 1'b0;
    assign fill_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ssr_gearbox.sv
//==============================================================================
// Module     : tb_ssr_gearbox
// Description: Directed self-checking bench for ssr_gearbox (4->6, 6->4, 8->8).
// Revision   : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_ssr_gearbox;

    localparam int NB = 12;
`ifdef SSR_GEARBOX_STATUS_EN
    localparam bit STATUS = 1'b1;
`else
    localparam bit STATUS = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic            a_ce, a_sync, a_ceo, a_err;
    logic [4*NB-1:0] a_di;
    logic [6*NB-1:0] a_do;
    logic [3:0]      a_fill;

    logic            b_ce, b_sync, b_ceo, b_err;
    logic [6*NB-1:0] b_di;
    logic [4*NB-1:0] b_do;
    logic [3:0]      b_fill;

    logic            c_ce, c_sync, c_ceo, c_err;
    logic [8*NB-1:0] c_di;
    logic [8*NB-1:0] c_do;
    logic [3:0]      c_fill;

    ssr_gearbox #(.NBITS(NB), .NIN(4), .NOUT(6)) u_a (
        .clk_i(clk), .rst_i(rst), .ce_i(a_ce), .sync_i(a_sync), .dat_i(a_di),
        .dat_o(a_do), .ce_o(a_ceo), .err_o(a_err), .fill_o(a_fill));

    ssr_gearbox #(.NBITS(NB), .NIN(6), .NOUT(4)) u_b (
        .clk_i(clk), .rst_i(rst), .ce_i(b_ce), .sync_i(b_sync), .dat_i(b_di),
        .dat_o(b_do), .ce_o(b_ceo), .err_o(b_err), .fill_o(b_fill));

    ssr_gearbox #(.NBITS(NB), .NIN(8), .NOUT(8)) u_c (
        .clk_i(clk), .rst_i(rst), .ce_i(c_ce), .sync_i(c_sync), .dat_i(c_di),
        .dat_o(c_do), .ce_o(c_ceo), .err_o(c_err), .fill_o(c_fill));

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // n consecutive samples s, s+1, ... with sample 0 in the low bits
    function automatic logic [127:0] ramp(input int n, input int s);
        logic [127:0] r;
        r = '0;
        for (int k = 0; k < n; k++) r[k*NB +: NB] = NB'(s + k);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // 4->6 continuous ramp from cnt=0: strobes 0,1,1; fill 4,2,0
    task automatic stream46(input int cycles, input bit do_sync);
        logic [127:0] t;
        int           idx;
        for (int n = 0; n < cycles; n++) begin
            t      = ramp(4, 4*n);
            a_di   = t[4*NB-1:0];
            a_ce   = 1'b1;
            a_sync = do_sync && (n == 0);
            tick();
            check($sformatf("a46 ce n=%0d", n), 128'(a_ceo), 128'((n % 3) != 0));
            check($sformatf("a46 fill n=%0d", n), 128'(a_fill),
                  STATUS ? 128'((n % 3 == 0) ? 4 : (n % 3 == 1) ? 2 : 0) : 128'(0));
            if ((n % 3) != 0) begin
                idx = (n / 3) * 2 + (n % 3) - 1;
                check($sformatf("a46 dat n=%0d", n), 128'(a_do), ramp(6, 6*idx));
            end
        end
        a_sync = 1'b0;
    endtask

    int t3_dat [5] = '{0, 4, 8, 18, 22};
    int t3_fill[5] = '{2, 4, 0, 2, 4};

    initial begin
        logic [127:0] t;
        logic [127:0] c_prev;

        a_ce = 0; a_sync = 0; a_di = '0;
        b_ce = 0; b_sync = 0; b_di = '0;
        c_ce = 0; c_sync = 0; c_di = '0;
        rst  = 1'b1;
        tick();
        check("rst a ce",   128'(a_ceo),  128'(0));
        check("rst a dat",  128'(a_do),   128'(0));
        check("rst a fill", 128'(a_fill), 128'(0));
        check("rst b ce",   128'(b_ceo),  128'(0));
        check("rst c dat",  128'(c_do),   128'(0));
        rst = 1'b0;

        // 4->6 with a single sync pulse, then resync while cnt=2
        stream46(5, 1'b1);
        check("a sync pre fill", 128'(a_fill), STATUS ? 128'(2) : 128'(0));
        t = ramp(4, 256); a_di = t[4*NB-1:0]; a_sync = 1'b1;
        tick();
        check("a sync ce0", 128'(a_ceo), 128'(0));
        t = ramp(4, 260); a_di = t[4*NB-1:0]; a_sync = 1'b0;
        tick();
        check("a sync ce1",  128'(a_ceo), 128'(1));
        check("a sync dat",  128'(a_do),  ramp(6, 256));

        // asynchronous reset between clock edges
        #2;
        a_ce = 1'b0;
        rst  = 1'b1;
        #1;
        check("arst ce",   128'(a_ceo),  128'(0));
        check("arst dat",  128'(a_do),   128'(0));
        check("arst fill", 128'(a_fill), 128'(0));
        check("arst err",  128'(a_err),  128'(0));
        tick();
        rst = 1'b0;
        stream46(6, 1'b0);
        a_ce = 1'b0;

        // 6->4 with ce pattern 1,1,0
        for (int n = 0; n < 6; n++) begin
            b_ce = (n % 3) != 2;
            t    = ramp(6, 6*((n / 3) * 2 + (n % 3)));
            b_di = b_ce ? t[6*NB-1:0] : '0;
            tick();
            check($sformatf("b110 ce n=%0d", n),  128'(b_ceo), 128'(1));
            check($sformatf("b110 dat n=%0d", n), 128'(b_do),  ramp(4, 4*n));
            check($sformatf("b110 err n=%0d", n), 128'(b_err), 128'(0));
            check($sformatf("b110 fill n=%0d", n), 128'(b_fill),
                  STATUS ? 128'((n % 3 == 0) ? 2 : (n % 3 == 1) ? 4 : 0) : 128'(0));
        end

        // 6->4 with ce held high: third input overflows and is dropped
        for (int n = 0; n < 5; n++) begin
            b_ce = 1'b1;
            t    = ramp(6, 6*n);
            b_di = t[6*NB-1:0];
            tick();
            check($sformatf("bovf ce n=%0d", n),  128'(b_ceo), 128'(1));
            check($sformatf("bovf dat n=%0d", n), 128'(b_do),  ramp(4, t3_dat[n]));
            check($sformatf("bovf err n=%0d", n), 128'(b_err),
                  (STATUS && n >= 2) ? 128'(1) : 128'(0));
            check($sformatf("bovf fill n=%0d", n), 128'(b_fill),
                  STATUS ? 128'(t3_fill[n]) : 128'(0));
        end
        b_ce = 1'b0;
        tick();
        check("bovf err sticky", 128'(b_err), STATUS ? 128'(1) : 128'(0));

        // 8->8 passthrough with one clock of latency
        tick();
        check("c idle ce", 128'(c_ceo), 128'(0));
        for (int n = 0; n < 4; n++) begin
            c_prev = ramp(8, 64 + 9*n);
            c_di   = c_prev[8*NB-1:0];
            c_ce   = 1'b1;
            tick();
            check($sformatf("c88 ce n=%0d", n),   128'(c_ceo),  128'(1));
            check($sformatf("c88 dat n=%0d", n),  128'(c_do),   c_prev);
            check($sformatf("c88 fill n=%0d", n), 128'(c_fill), 128'(0));
        end
        c_ce = 1'b0;
        tick();
        check("c88 stop ce", 128'(c_ceo), 128'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/ssr_gearbox.md
Name: ssr_gearbox

Overview:
- Parametrised sample-rate regrouper for SSR datapaths: accepts NIN samples per qualified clock and emits NOUT samples per output strobe.
- Sits in front of or behind SSR filters that need a different samples-per-clock grouping, e.g. 4->6 into the two-thirds lowpass and 6->4 out of it.
- Generalises the fixed 4->6 and 6->4 converters: any NIN/NOUT, an input qualifier, a resync input, and optional overflow status.

Parameters:
- NBITS, 12, bits per sample.
- NIN, 4, samples per input word (1..16).
- NOUT, 6, samples per output word (1..16).
- Derived: BUF = NIN+NOUT-1 samples of storage; CNTW = clog2(BUF+1).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset; asynchronous, active-high.
- ce_i  in  1  input qualifier; dat_i is accepted only when high.
- sync_i  in  1  resync: discard buffered samples this cycle.
- dat_i  in  NIN*NBITS  input samples; sample 0 is the oldest.
- dat_o  out  NOUT*NBITS  output samples; sample 0 is the oldest.
- ce_o  out  1  dat_o holds a new word (one-cycle strobe).
- err_o  out  1  sticky overflow flag (see Optional Feature).
- fill_o  out  CNTW  buffered sample count (see Optional Feature).

Behaviour:
- One clock; reset is asynchronous and active-high: rst_i clears cnt, dat_o, ce_o, err_o and fill_o to 0 immediately, independent of clk_i.
- State is buf (BUF samples, oldest at index 0) plus cnt (0..BUF).
- Each clock:
  - base = sync_i ? 0 : cnt.
  - acc = ce_i ? NIN : 0.
  - total = base + acc; incoming samples occupy buffer positions base..base+NIN-1.
- Overflow: ce_i && base+NIN > BUF. dat_i is dropped (acc = 0) and the error event fires. The emit decision still proceeds.
- Emit when total >= NOUT:
  - dat_o <= positions 0..NOUT-1; ce_o <= 1.
  - Remaining samples shift down by NOUT; cnt <= total-NOUT.
- Otherwise: ce_o <= 0, dat_o holds its value, cnt <= total.
- At most one emit per clock. NOUT <= total holds only when enough samples exist; no partial words are ever output.
- Latency: dat_o/ce_o are registered. The last sample of a group arriving with ce_i on cycle n appears on dat_o with ce_o=1 on cycle n+1.
- Steady state with ce_i tied high and NIN<=NOUT: ce_o duty = NIN/NOUT, periodic over NOUT/gcd clocks. From cnt=0, 4->6 gives the ce_o pattern 0,1,1 repeating.
- NIN>NOUT requires upstream to gate ce_i so that long-term NIN*duty(ce_i) <= NOUT. The 6->4 case with ce_i pattern 1,1,0 never overflows.
- sync_i and ce_i in the same cycle: old contents are discarded and the new input is written at position 0. Emit occurs if NIN >= NOUT.
- sync_i with ce_i=0: cnt <= 0, ce_o <= 0.
- Samples are passed bit-exact; there is no arithmetic.

Optional Feature:
- Macro SSR_GEARBOX_STATUS_EN.
- Defined:
  - err_o sets on the cycle after any overflow event and stays set until rst_i.
  - fill_o is the registered cnt after each update.
- Not defined:
  - err_o and fill_o are tied to 0.
  - Overflow still drops dat_i silently; datapath behaviour is identical.

Test Plan:
- NIN=4, NOUT=6, ce_i=1, sync_i pulsed once, dat_i carrying ramp 0,1,2,...:
  - ce_o pattern 0,1,1 repeating.
  - First word {5,4,3,2,1,0}, then {11..6}, then {17..12}.
  - First strobe 2 cycles after sync.
- NIN=6, NOUT=4, ce_i pattern 1,1,0, ramp input:
  - ce_o high every cycle; output words {3..0}, {7..4}, {11..8}.
  - err_o stays 0; fill_o sequence 2,4,0.
- NIN=6, NOUT=4, ce_i held high:
  - Overflow on the third input cycle; that input (samples 12..17) is dropped.
  - err_o=1 from the next cycle and sticky.
  - Output continues {11..8}, then an emit only after the next accepted input.
- 4->6 with sync_i asserted while cnt=2:
  - Buffered samples are discarded; the next strobe contains only post-sync samples 0..5 of the new ramp.
- rst_i asserted asynchronously mid-stream (between clock edges):
  - dat_o=0, ce_o=0, err_o=0, fill_o=0 immediately.
  - After release, the 4->6 pattern restarts at 0,1,1.
- NIN=NOUT=8, ce_i=1:
  - ce_o high every cycle from the cycle after the first input; dat_o equals dat_i delayed by 1 clock.
  - fill_o stays 0.
